// File: rtl/seq_sm_alu_pkg.sv
// Shared definitions for the sequential sign-magnitude ALU: op codes, FSM states
// and the result-width helper.
package seq_sm_alu_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_MOD = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ADDSUB,
    MUL,
    MOD,
    DONE
  } state_t;

  function automatic int res_w(input int mag_w);
    return 2 * mag_w + 1;
  endfunction

endpackage

// File: rtl/seq_sm_alu_if.sv
// Operand/request and result/flag bundle between the keypad front end (master)
// and the sequential ALU (slave).
interface seq_sm_alu_if #(
  parameter int MAG_W = 2
) ();
  import seq_sm_alu_pkg::*;

  logic                    start;
  logic [MAG_W:0]          a;
  logic [MAG_W:0]          b;
  logic [1:0]              sel;
  logic                    busy;
  logic                    done;
  logic [res_w(MAG_W)-1:0] result;
  logic                    z;
  logic                    dz;

  modport master (
    output start, a, b, sel,
    input  busy, done, result, z, dz
  );

  modport slave (
    input  start, a, b, sel,
    output busy, done, result, z, dz
  );

endinterface

// File: rtl/seq_sm_alu_addsub.sv
// Combinational sign-magnitude add/subtract core; its compare/difference path is
// also used for the restoring-divide step. Callers keep sums within W bits.
module sm_addsub #(
  parameter int W = 3
) (
  input  logic         a_sign_i,
  input  logic [W-1:0] a_mag_i,
  input  logic         b_sign_i,
  input  logic [W-1:0] b_mag_i,
  output logic         sign_o,
  output logic [W-1:0] mag_o,
  output logic         ge_o,
  output logic [W-1:0] diff_o
);

  always_comb begin
    ge_o   = (a_mag_i >= b_mag_i);
    diff_o = ge_o ? (a_mag_i - b_mag_i) : (b_mag_i - a_mag_i);
    if (a_sign_i == b_sign_i) begin
      mag_o  = a_mag_i + b_mag_i;
      sign_o = a_sign_i;
    end else begin
      mag_o  = diff_o;
      sign_o = ge_o ? a_sign_i : b_sign_i;
    end
    if (mag_o == '0) sign_o = 1'b0;
  end

endmodule

// File: rtl/seq_sm_alu.sv
// Multi-cycle sign-magnitude ALU: shift-add multiply, restoring-divide remainder,
// single-cycle add/sub. Define SEQ_SM_ALU_EARLY_TERM_EN for early multiply exit.
module seq_sm_alu
  import seq_sm_alu_pkg::*;
#(
  parameter int MAG_W = 2
) (
  input logic         clk,
  input logic         rst_n,
  seq_sm_alu_if.slave bus
);

  localparam int RW = res_w(MAG_W);
  localparam int PW = 2 * MAG_W;
  localparam int CW = $clog2(MAG_W + 1);

  state_t           state_q, state_d;
  logic             a_sign_q, a_sign_d, b_sign_q, b_sign_d, sub_q, sub_d;
  logic [MAG_W-1:0] a_mag_q, a_mag_d, b_mag_q, b_mag_d, shreg_q, shreg_d;
  logic [PW-1:0]    acc_q, acc_d, mcand_q, mcand_d;
  logic [MAG_W:0]   rem_q, rem_d, rem_sh;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    result_q, result_d;
  logic             z_q, z_d, dz_q, dz_d;
  logic             mul_last;

  logic             as_sign, as_ge;
  logic [MAG_W:0]   as_a_mag, as_mag, as_diff;

  function automatic logic [RW-1:0] pack(input logic s, input logic [PW-1:0] m);
    return {s & (|m), m};
  endfunction

  // The remainder step borrows the add/sub compare path for its trial subtraction.
  assign rem_sh   = {rem_q[MAG_W-1:0], shreg_q[MAG_W-1]};
  assign as_a_mag = (state_q == MOD) ? rem_sh : {1'b0, a_mag_q};

  sm_addsub #(.W(MAG_W + 1)) u_addsub (
    .a_sign_i (a_sign_q),
    .a_mag_i  (as_a_mag),
    .b_sign_i (b_sign_q ^ sub_q),
    .b_mag_i  ({1'b0, b_mag_q}),
    .sign_o   (as_sign),
    .mag_o    (as_mag),
    .ge_o     (as_ge),
    .diff_o   (as_diff)
  );

`ifdef SEQ_SM_ALU_EARLY_TERM_EN
  assign mul_last = (cnt_q == CW'(MAG_W)) || (shreg_q == '0) || (mcand_q == '0);
`else
  assign mul_last = (cnt_q == CW'(MAG_W));
`endif

  always_comb begin
    state_d  = state_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    sub_d    = sub_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    z_d      = z_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          a_sign_d = bus.a[MAG_W];
          a_mag_d  = bus.a[MAG_W-1:0];
          b_sign_d = bus.b[MAG_W];
          b_mag_d  = bus.b[MAG_W-1:0];
          sub_d    = (bus.sel == OP_SUB);
          cnt_d    = '0;
          acc_d    = '0;
          rem_d    = '0;
          mcand_d  = {{MAG_W{1'b0}}, bus.a[MAG_W-1:0]};
          shreg_d  = (bus.sel == OP_MOD) ? bus.a[MAG_W-1:0] : bus.b[MAG_W-1:0];
          case (bus.sel)
            OP_MUL:  state_d = MUL;
            OP_MOD:  state_d = MOD;
            default: state_d = ADDSUB;
          endcase
        end
      end
      ADDSUB: begin
        result_d = {as_sign, {(MAG_W-1){1'b0}}, as_mag};
        z_d      = (as_mag == '0);
        dz_d     = 1'b0;
        state_d  = DONE;
      end
      MUL: begin
        if (mul_last) begin
          result_d = pack(a_sign_q ^ b_sign_q, acc_q);
          z_d      = (acc_q == '0);
          dz_d     = 1'b0;
          state_d  = DONE;
        end else begin
          if (shreg_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      MOD: begin
        if (b_mag_q == '0) begin
          result_d = '0;
          z_d      = 1'b1;
          dz_d     = 1'b1;
          state_d  = DONE;
        end else if (cnt_q == CW'(MAG_W)) begin
          result_d = pack(a_sign_q, {{(MAG_W-1){1'b0}}, rem_q});
          z_d      = (rem_q == '0);
          dz_d     = 1'b0;
          state_d  = DONE;
        end else begin
          rem_d   = as_ge ? as_diff : rem_sh;
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      sub_q    <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      shreg_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      sub_q    <= sub_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      z_q      <= z_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy   = (state_q == ADDSUB) || (state_q == MUL) || (state_q == MOD);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.z      = z_q;
  assign bus.dz     = dz_q;

endmodule

// File: tb/tb_seq_sm_alu.sv
// Scoreboard bench for seq_sm_alu at MAG_W=2 and MAG_W=4; latency is counted in
// edges including the accept edge.
module tb_seq_sm_alu;
  import seq_sm_alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q2[$];
  exp_t q4[$];

  seq_sm_alu_if #(.MAG_W(2)) bus2 ();
  seq_sm_alu_if #(.MAG_W(4)) bus4 ();

  seq_sm_alu #(.MAG_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  seq_sm_alu #(.MAG_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst_n && bus2.done) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL done2_unexpected: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q2.pop_front();
        chk("res2", 32'(bus2.result), e.res);
        chk("z2", 32'(bus2.z), 32'(e.z));
        chk("dz2", 32'(bus2.dz), 32'(e.dz));
        chk("lat2", 32'(cyc - e.acc + 1), 32'(e.lat));
        chk("busy_in_done2", 32'(bus2.busy), 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && bus4.done) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL done4_unexpected: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q4.pop_front();
        chk("res4", 32'(bus4.result), e.res);
        chk("z4", 32'(bus4.z), 32'(e.z));
        chk("dz4", 32'(bus4.dz), 32'(e.dz));
        chk("lat4", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic wait_idle2();
    int n = 0;
    while (bus2.busy && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL timeout2: busy still 1 after 100 cycles, expected 0");
    end
  endtask

  task automatic wait_idle4();
    int n = 0;
    while (bus4.busy && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL timeout4: busy still 1 after 100 cycles, expected 0");
    end
  endtask

  // Called at a negedge; issues one request and returns at the next negedge.
  task automatic issue2(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sel,
                        input logic [4:0] res, input logic z, input logic dz, input int lat);
    wait_idle2();
    bus2.start = 1'b1; bus2.a = a; bus2.b = b; bus2.sel = sel;
    q2.push_back('{res: 32'(res), z: z, dz: dz, lat: lat, acc: cyc + 1});
    @(negedge clk);
    bus2.start = 1'b0;
  endtask

  task automatic issue4(input logic [4:0] a, input logic [4:0] b, input logic [1:0] sel,
                        input logic [8:0] res, input logic z, input logic dz, input int lat);
    wait_idle4();
    bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.sel = sel;
    q4.push_back('{res: 32'(res), z: z, dz: dz, lat: lat, acc: cyc + 1});
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  // Reference built on signed integer arithmetic rather than sign-magnitude logic.
  function automatic void model2(input int sel, input logic [2:0] a, input logic [2:0] b,
                                 output logic [4:0] res, output logic z, output logic dz,
                                 output int lat);
    int ma, mb, va, vb, s, mag;
    logic sg;
    ma = int'(a[1:0]);
    mb = int'(b[1:0]);
    dz = 1'b0;
    lat = 2;
    mag = 0;
    sg = 1'b0;
    case (sel)
      0: begin
        mag = ma * mb;
        sg  = a[2] ^ b[2];
`ifdef SEQ_SM_ALU_EARLY_TERM_EN
        lat = (ma == 0) ? 2 : 2 + ((mb >= 2) ? 2 : mb);
`else
        lat = 4;
`endif
      end
      1: begin
        if (mb == 0) begin
          dz = 1'b1;
        end else begin
          mag = ma % mb;
          sg  = a[2];
          lat = 4;
        end
      end
      default: begin
        va  = a[2] ? -ma : ma;
        vb  = (b[2] ^ (sel == 3)) ? -mb : mb;
        s   = va + vb;
        mag = (s < 0) ? -s : s;
        sg  = (s < 0);
      end
    endcase
    if (mag == 0) sg = 1'b0;
    res = {sg, 4'(mag)};
    z   = (mag == 0);
  endfunction

  initial begin
    logic [4:0] er;
    logic ez, edz;
    int el, n;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.sel = OP_ADD;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.sel = OP_ADD;

    #3;
    chk("rst_busy", 32'(bus2.busy), 0);
    chk("rst_done", 32'(bus2.done), 0);
    chk("rst_result", 32'(bus2.result), 0);
    chk("rst_z", 32'(bus2.z), 0);
    chk("rst_dz", 32'(bus2.dz), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed MAG_W=2 vectors
    issue2(3'b111, 3'b010, OP_MUL, 5'b10110, 1'b0, 1'b0, 4);
    issue2(3'b111, 3'b010, OP_MOD, 5'b10001, 1'b0, 1'b0, 4);
    issue2(3'b110, 3'b100, OP_MOD, 5'b00000, 1'b1, 1'b1, 2);
    issue2(3'b011, 3'b111, OP_ADD, 5'b00000, 1'b1, 1'b0, 2);
    issue2(3'b101, 3'b011, OP_SUB, 5'b10100, 1'b0, 1'b0, 2);
`ifdef SEQ_SM_ALU_EARLY_TERM_EN
    issue2(3'b011, 3'b001, OP_MUL, 5'b00011, 1'b0, 1'b0, 3);
    issue2(3'b000, 3'b111, OP_MUL, 5'b00000, 1'b1, 1'b0, 2);
`else
    issue2(3'b011, 3'b001, OP_MUL, 5'b00011, 1'b0, 1'b0, 4);
    issue2(3'b000, 3'b111, OP_MUL, 5'b00000, 1'b1, 1'b0, 4);
`endif

    // Directed MAG_W=4 vectors
    issue4(5'b01111, 5'b01111, OP_MUL, 9'b0_11100001, 1'b0, 1'b0, 6);
    issue4(5'b10111, 5'b00101, OP_MOD, 9'b1_00000010, 1'b0, 1'b0, 6);

    // Start held high while busy with changing operands: only the first request runs
    wait_idle2();
    bus2.start = 1'b1; bus2.a = 3'b111; bus2.b = 3'b010; bus2.sel = OP_MUL;
    q2.push_back('{res: 32'h16, z: 1'b0, dz: 1'b0, lat: 4, acc: cyc + 1});
    @(negedge clk);
    bus2.a = 3'b011; bus2.b = 3'b011; bus2.sel = OP_ADD;
    @(negedge clk);
    bus2.a = 3'b001; bus2.b = 3'b000; bus2.sel = OP_MOD;
    @(negedge clk);
    bus2.start = 1'b0;

    // Abort a multiply in its third cycle with an asynchronous reset
    wait_idle2();
    bus2.start = 1'b1; bus2.a = 3'b011; bus2.b = 3'b011; bus2.sel = OP_MUL;
    @(negedge clk);
    bus2.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("busy_before_rst", 32'(bus2.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus2.busy), 0);
    chk("midrst_done", 32'(bus2.done), 0);
    chk("midrst_result", 32'(bus2.result), 0);
    chk("midrst_z", 32'(bus2.z), 0);
    chk("midrst_dz", 32'(bus2.dz), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("postrst_busy", 32'(bus2.busy), 0);
    chk("postrst_result", 32'(bus2.result), 0);

    // Exhaustive MAG_W=2 sweep
    for (int s = 0; s < 4; s++) begin
      for (int ia = 0; ia < 8; ia++) begin
        for (int ib = 0; ib < 8; ib++) begin
          model2(s, 3'(ia), 3'(ib), er, ez, edz, el);
          issue2(3'(ia), 3'(ib), 2'(s), er, ez, edz, el);
        end
      end
    end

    n = 0;
    while ((q2.size() != 0 || q4.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("pending2", 32'(q2.size()), 0);
    chk("pending4", 32'(q4.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
